mem_1r1w_fwd_init: RTL and testbench
====================================

Name: mem_1r1w_fwd_init

Overview:
- Single-clock, simple-dual-port (one read, one write) RAM with per-byte write enables.
- Read-during-write forwarding to the same address.
- Selectable 1- or 2-cycle read latency.
- Built-in post-reset initialisation sequencer that fills every word with INIT_VALUE before accepting traffic.
- Drop-in successor to the dual-clock 1R1W memory wrapper for single-clock-domain tables (QP context, doorbell and credit tables) that must start from a known state.

Parameters:
- WIDTH_ADDR, 8, address width; depth = 2^WIDTH_ADDR words.
- WIDTH_DATA, 32, word width; must be a multiple of 8.
- INIT_VALUE, 0, value written to every word after reset; WIDTH_DATA bits.
- DOUT_REG, "false", "false": read latency 1 cycle; "true": extra output register, read latency 2 cycles.
- RAM_STYLE_MODE, "block", synthesis hint for the array: "block", "distributed" or "registers".

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- init_done  output  1  high once initialisation is complete; user access accepted only while high.
- wen  input  1  write request.
- waddr  input  WIDTH_ADDR  write address.
- wbe  input  WIDTH_DATA/8  byte-lane write enables; bit i covers din[8i+7:8i].
- din  input  WIDTH_DATA  write data.
- ren  input  1  read request.
- raddr  input  WIDTH_ADDR  read address.
- dout  output  WIDTH_DATA  read data; holds its last value between reads.
- dout_vld  output  1  one-cycle pulse per accepted read, aligned with dout.

Behaviour:
- Reset values (asynchronous): FSM = INIT, init counter = 0, init_done = 0, dout = 0, dout_vld = 0, all pipeline registers and valid bits = 0. Array contents are not reset directly; the sequencer overwrites them.
- FSM state INIT:
  - Each cycle writes INIT_VALUE (all lanes) to address = counter, then increments the counter.
  - After writing address 2^WIDTH_ADDR-1, the next state is RUN. No counter wrap or overflow: the terminal condition is counter all-ones.
  - INIT lasts exactly 2^WIDTH_ADDR cycles after reset deassertion.
  - wen and ren are ignored (dropped, not queued); dout_vld stays 0.
- FSM state RUN:
  - init_done = 1 (registered; rises in the first RUN cycle).
  - Stays in RUN until rst.
- Write: at a rising edge with wen=1 and init_done=1, for each lane i with wbe[i]=1, mem[waddr] lane i <= din lane i. Other lanes are unchanged. wen=1 with wbe=0 is a no-op.
- Read:
  - Accepted at a rising edge with ren=1 and init_done=1.
  - DOUT_REG="false": dout and dout_vld update at the next edge (latency 1).
  - DOUT_REG="true": update one edge later (latency 2).
  - Back-to-back reads are supported every cycle at full throughput.
- Forwarding:
  - A read returns the word as it stands after every write accepted up to and including the edge that accepts the read.
  - Same-edge collision (wen & ren & waddr==raddr): lanes with wbe set return din; other lanes return the prior stored contents.
  - Writes accepted after the read edge are never reflected in that read's data, including the intervening cycle when DOUT_REG="true".
  - Implementation: register the bypass data and lane mask alongside the array read, and merge them at the output.
- Reset mid-operation:
  - In-flight reads are discarded; dout_vld = 0 immediately.
  - The FSM returns to INIT and restarts at address 0; a full re-initialisation follows.
- No error outputs. Addresses are full range, so no out-of-range case exists.

Test Plan:
- WIDTH_ADDR=4, INIT_VALUE=32'hA5A5A5A5: release rst, hold ren=1 -> init_done rises 16 cycles after release, no dout_vld before it. Then reading addresses 0..15 all return A5A5A5A5.
- Write addr 3 = 32'h11223344 with wbe=4'hF, then read addr 3 -> dout=11223344 with dout_vld one cycle later (DOUT_REG="false") or two cycles later (DOUT_REG="true").
- Addr 5 holds 32'hAABBCCDD. On the same edge, write din=32'h00112233 with wbe=4'b0101 and read addr 5 -> dout=AA11CC33.
- DOUT_REG="true": read addr 7 (holding 0), write addr 7 = 32'hFFFFFFFF on the next edge -> returned data is 0. A following read returns FFFFFFFF.
- Pulse wen/ren during INIT to addr 2 with data 32'hDEADBEEF -> no dout_vld. After init_done, addr 2 reads INIT_VALUE.
- Assert rst for 1 cycle mid-stream, with a read in flight and addr 9 previously written 32'h12345678 -> dout_vld = 0 immediately, init_done = 0 for 16 cycles, then addr 9 reads INIT_VALUE.

Source files
------------

// File: rtl/mem_1r1w_fwd_init.sv
// Single-clock 1R1W RAM with byte-lane writes, same-address read-during-write
// forwarding and a post-reset sequencer that fills every word with INIT_VALUE.
module mem_1r1w_fwd_init #(
    parameter int                      WIDTH_ADDR     = 8,
    parameter int                      WIDTH_DATA     = 32,
    parameter logic [WIDTH_DATA-1:0]   INIT_VALUE     = '0,
    parameter string                   DOUT_REG       = "false",
    parameter string                   RAM_STYLE_MODE = "block"
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      init_done,
    input  logic                      wen,
    input  logic [WIDTH_ADDR-1:0]     waddr,
    input  logic [WIDTH_DATA/8-1:0]   wbe,
    input  logic [WIDTH_DATA-1:0]     din,
    input  logic                      ren,
    input  logic [WIDTH_ADDR-1:0]     raddr,
    output logic [WIDTH_DATA-1:0]     dout,
    output logic                      dout_vld
);

    localparam int                    NUM_LANES = WIDTH_DATA / 8;
    localparam int                    DEPTH     = 1 << WIDTH_ADDR;
    localparam logic [WIDTH_ADDR-1:0] ADDR_LAST = '1;

    generate
        if ((WIDTH_DATA % 8) != 0) begin : g_bad_width
            $error("mem_1r1w_fwd_init: WIDTH_DATA must be a multiple of 8");
        end
        if (RAM_STYLE_MODE != "block" && RAM_STYLE_MODE != "distributed" &&
            RAM_STYLE_MODE != "registers") begin : g_bad_style
            $error("mem_1r1w_fwd_init: unknown RAM_STYLE_MODE");
        end
    endgenerate

    function automatic logic [WIDTH_DATA-1:0] lane_merge(
        input logic [WIDTH_DATA-1:0] ram_word,
        input logic [WIDTH_DATA-1:0] fwd_word,
        input logic [NUM_LANES-1:0]  mask
    );
        logic [WIDTH_DATA-1:0] merged;
        merged = ram_word;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (mask[i]) merged[8*i +: 8] = fwd_word[8*i +: 8];
        end
        return merged;
    endfunction

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state;
    logic [WIDTH_ADDR-1:0]   init_cnt;

    (* ram_style = RAM_STYLE_MODE *)
    logic [WIDTH_DATA-1:0]   mem [DEPTH];

    logic                    wr_user;
    logic                    rd_user;
    logic                    mem_we;
    logic [WIDTH_ADDR-1:0]   mem_waddr;
    logic [NUM_LANES-1:0]    mem_wbe;
    logic [WIDTH_DATA-1:0]   mem_wdata;

    logic [WIDTH_DATA-1:0]   ram_q_p0;
    logic [WIDTH_DATA-1:0]   fwd_data_p0;
    logic [NUM_LANES-1:0]    fwd_mask_p0;
    logic                    vld_p0;
    logic [WIDTH_DATA-1:0]   rd_word_p0;

    assign wr_user = wen & init_done;
    assign rd_user = ren & init_done;

    // Fill sequencer: the counter holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == ADDR_LAST) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + WIDTH_ADDR'(1);
                    end
                end
                ST_RUN: begin
                    init_done <= 1'b1;
                end
                default: begin
                    state     <= ST_INIT;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_we    = wr_user;
        mem_waddr = waddr;
        mem_wbe   = wbe;
        mem_wdata = din;
        if (state == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt;
            mem_wbe   = '1;
            mem_wdata = INIT_VALUE;
        end
    end

    // Array and its read register stay out of reset so they map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (mem_wbe[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
        if (rd_user) ram_q_p0 <= mem[raddr];
    end

    // Stage p0: bypass lanes for a same-edge write to the address being read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0      <= 1'b0;
            fwd_mask_p0 <= '0;
            fwd_data_p0 <= '0;
        end else begin
            vld_p0 <= rd_user;
            if (rd_user) begin
                fwd_mask_p0 <= (wr_user && (waddr == raddr)) ? wbe : '0;
                fwd_data_p0 <= din;
            end
        end
    end

    assign rd_word_p0 = lane_merge(ram_q_p0, fwd_data_p0, fwd_mask_p0);

    generate
        if (DOUT_REG == "true") begin : g_dout_reg
            logic                  vld_p1;
            logic [WIDTH_DATA-1:0] rd_word_p1;

            // Stage p1: extra output register, then dout.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_p1     <= 1'b0;
                    rd_word_p1 <= '0;
                    dout_vld   <= 1'b0;
                    dout       <= '0;
                end else begin
                    vld_p1   <= vld_p0;
                    dout_vld <= vld_p1;
                    if (vld_p0) rd_word_p1 <= rd_word_p0;
                    if (vld_p1) dout       <= rd_word_p1;
                end
            end
        end else begin : g_dout_direct
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_vld <= 1'b0;
                    dout     <= '0;
                end else begin
                    dout_vld <= vld_p0;
                    if (vld_p0) dout <= rd_word_p0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_mem_1r1w_fwd_init.sv
// Bench for mem_1r1w_fwd_init: both read latencies side by side, directed
// vector table, hand-written reset/init sequences and randomized traffic.
module tb_mem_1r1w_fwd_init;

    localparam int          AW    = 4;
    localparam int          DW    = 32;
    localparam int          NB    = DW / 8;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] INIT  = 32'hA5A5A5A5;

    logic          clk = 1'b0;
    logic          rst;
    logic          wen, ren;
    logic [AW-1:0] waddr, raddr;
    logic [NB-1:0] wbe;
    logic [DW-1:0] din;
    logic          init_done1, init_done2, dout_vld1, dout_vld2;
    logic [DW-1:0] dout1, dout2;

    int n_cmp, n_fail;

    mem_1r1w_fwd_init #(
        .WIDTH_ADDR(AW), .WIDTH_DATA(DW), .INIT_VALUE(INIT),
        .DOUT_REG("false"), .RAM_STYLE_MODE("block")
    ) u_dut1 (
        .clk(clk), .rst(rst), .init_done(init_done1),
        .wen(wen), .waddr(waddr), .wbe(wbe), .din(din),
        .ren(ren), .raddr(raddr), .dout(dout1), .dout_vld(dout_vld1)
    );

    mem_1r1w_fwd_init #(
        .WIDTH_ADDR(AW), .WIDTH_DATA(DW), .INIT_VALUE(INIT),
        .DOUT_REG("true"), .RAM_STYLE_MODE("distributed")
    ) u_dut2 (
        .clk(clk), .rst(rst), .init_done(init_done2),
        .wen(wen), .waddr(waddr), .wbe(wbe), .din(din),
        .ren(ren), .raddr(raddr), .dout(dout2), .dout_vld(dout_vld2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents as an array, reads as due-dated queue entries.
    typedef struct { int due; logic [DW-1:0] data; } pend_t;

    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_done;
    int            m_init_cyc;
    int            cyc;
    pend_t         q1[$], q2[$];
    logic [DW-1:0] e_dout1, e_dout2;
    bit            e_vld1, e_vld2;

    function automatic logic [DW-1:0] byte_mask(input logic [NB-1:0] be);
        logic [DW-1:0] m = '0;
        for (int i = 0; i < NB; i++) if (be[i]) m |= (32'hFF << (8 * i));
        return m;
    endfunction

    task automatic model_reset();
        m_done     = 1'b0;
        m_init_cyc = 0;
        q1.delete();
        q2.delete();
        e_vld1  = 1'b0;
        e_vld2  = 1'b0;
        e_dout1 = '0;
        e_dout2 = '0;
    endtask

    task automatic model_edge();
        logic [DW-1:0] word, m;
        if (rst) begin
            model_reset();
            return;
        end
        cyc++;
        e_vld1 = 1'b0;
        if (q1.size() != 0 && q1[0].due == cyc) begin
            e_dout1 = q1[0].data; e_vld1 = 1'b1; void'(q1.pop_front());
        end
        e_vld2 = 1'b0;
        if (q2.size() != 0 && q2[0].due == cyc) begin
            e_dout2 = q2[0].data; e_vld2 = 1'b1; void'(q2.pop_front());
        end
        if (!m_done) begin
            m_init_cyc++;
            if (m_init_cyc == DEPTH) begin
                for (int a = 0; a < DEPTH; a++) ref_mem[a] = INIT;
                m_done = 1'b1;
            end
            return;
        end
        m = byte_mask(wbe);
        if (ren) begin
            word = ref_mem[raddr];
            if (wen && waddr == raddr) word = (word & ~m) | (din & m);
            q1.push_back('{cyc + 1, word});
            q2.push_back('{cyc + 2, word});
        end
        if (wen) ref_mem[waddr] = (ref_mem[waddr] & ~m) | (din & m);
    endtask

    task automatic model_check();
        chk("init_done_lat1", init_done1, m_done);
        chk("init_done_lat2", init_done2, m_done);
        chk("dout_vld_lat1",  dout_vld1,  e_vld1);
        chk("dout_vld_lat2",  dout_vld2,  e_vld2);
        chk("dout_lat1",      dout1,      e_dout1);
        chk("dout_lat2",      dout2,      e_dout2);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
        model_check();
    endtask

    task automatic idle();
        wen = 1'b0; waddr = '0; wbe = '0; din = '0;
        ren = 1'b0; raddr = '0;
    endtask

    task automatic wait_init(input string name);
        int got = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (init_done1 === 1'b1) begin
                got = c;
                break;
            end
        end
        chk(name, got, 16);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
        wen = 1'b0; ren = 1'b1; raddr = a;
        tick();
        ren = 1'b0;
        tick();
        chk({name, "_vld1"}, dout_vld1, 1'b1);
        chk({name, "_dout1"}, dout1, exp);
        tick();
        chk({name, "_vld2"}, dout_vld2, 1'b1);
        chk({name, "_dout2"}, dout2, exp);
    endtask

    typedef struct {
        logic          wen;
        logic [AW-1:0] waddr;
        logic [NB-1:0] wbe;
        logic [DW-1:0] din;
        logic          ren;
        logic [AW-1:0] raddr;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   nv;

    function automatic vec_t mk(input logic w, input int wa, input logic [NB-1:0] be,
                                input logic [DW-1:0] d, input logic r, input int ra,
                                input logic [DW-1:0] e);
        vec_t v;
        v.wen = w; v.waddr = AW'(wa); v.wbe = be; v.din = d;
        v.ren = r; v.raddr = AW'(ra); v.exp = e;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        wen = v.wen; waddr = v.waddr; wbe = v.wbe; din = v.din;
        ren = v.ren; raddr = v.raddr;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0;
        rst = 1'b1;
        idle();
        model_reset();
        repeat (3) tick();
        chk("reset_init_done1", init_done1, 1'b0);
        chk("reset_init_done2", init_done2, 1'b0);
        chk("reset_dout_vld1",  dout_vld1,  1'b0);
        chk("reset_dout_vld2",  dout_vld2,  1'b0);
        chk("reset_dout1",      dout1,      '0);
        chk("reset_dout2",      dout2,      '0);

        // Requests held during INIT must be dropped.
        wen = 1'b1; waddr = 4'd2; wbe = '1; din = 32'hDEADBEEF;
        ren = 1'b1; raddr = 4'd2;
        rst = 1'b0;
        wait_init("init_latency");
        idle();

        for (int a = 0; a < DEPTH; a++) vecs.push_back(mk(0, 0, 4'h0, '0, 1, a, INIT));
        vecs.push_back(mk(1, 3,  4'hF,    32'h11223344, 0, 0,  '0));
        vecs.push_back(mk(0, 0,  4'h0,    '0,           1, 3,  32'h11223344));
        vecs.push_back(mk(1, 5,  4'hF,    32'hAABBCCDD, 0, 0,  '0));
        vecs.push_back(mk(1, 5,  4'b0101, 32'h00112233, 1, 5,  32'hAA11CC33));
        vecs.push_back(mk(1, 7,  4'hF,    32'h00000000, 0, 0,  '0));
        vecs.push_back(mk(0, 0,  4'h0,    '0,           1, 7,  32'h00000000));
        vecs.push_back(mk(1, 7,  4'hF,    32'hFFFFFFFF, 0, 0,  '0));
        vecs.push_back(mk(0, 0,  4'h0,    '0,           1, 7,  32'hFFFFFFFF));
        vecs.push_back(mk(1, 3,  4'h0,    32'h00000000, 1, 3,  32'h11223344));
        vecs.push_back(mk(1, 10, 4'hF,    32'hCAFEF00D, 1, 10, 32'hCAFEF00D));
        vecs.push_back(mk(1, 10, 4'b1000, 32'h11000000, 1, 10, 32'h11FEF00D));
        vecs.push_back(mk(0, 0,  4'h0,    '0,           1, 10, 32'h11FEF00D));
        vecs.push_back(mk(0, 0,  4'h0,    '0,           1, 5,  32'hAA11CC33));
        nv = vecs.size();

        for (int j = 0; j <= nv + 1; j++) begin
            if (j < nv) drive(vecs[j]);
            else idle();
            tick();
            if (j >= 1 && j - 1 < nv && vecs[j-1].ren) begin
                chk($sformatf("vec%0d_vld1", j - 1), dout_vld1, 1'b1);
                chk($sformatf("vec%0d_dout1", j - 1), dout1, vecs[j-1].exp);
            end
            if (j >= 2 && vecs[j-2].ren) begin
                chk($sformatf("vec%0d_vld2", j - 2), dout_vld2, 1'b1);
                chk($sformatf("vec%0d_dout2", j - 2), dout2, vecs[j-2].exp);
            end
        end

        for (int k = 0; k < 600; k++) begin
            wen   = ($urandom_range(0, 2) != 0);
            waddr = AW'($urandom_range(0, DEPTH - 1));
            wbe   = NB'($urandom);
            din   = $urandom;
            ren   = ($urandom_range(0, 1) != 0);
            raddr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, DEPTH - 1));
            tick();
        end
        idle();
        tick();

        // Reset with a read of addr 9 in flight.
        wen = 1'b1; waddr = 4'd9; wbe = '1; din = 32'h12345678;
        tick();
        wen = 1'b0; ren = 1'b1; raddr = 4'd9;
        tick();
        ren = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_dout_vld1",  dout_vld1,  1'b0);
        chk("midrst_dout_vld2",  dout_vld2,  1'b0);
        chk("midrst_init_done1", init_done1, 1'b0);
        chk("midrst_init_done2", init_done2, 1'b0);
        tick();
        rst = 1'b0;
        wait_init("reinit_latency");
        do_read(4'd9, INIT, "reinit_addr9");
        do_read(4'd2, INIT, "reinit_addr2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
